// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and holds the word for decode.
// Next PC comes from {jr, j, branch}. A misaligned target or a memory timeout parks the stage in a sticky error.
module pc_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  pc_next_c,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jaddr,
  input  logic [31:0] rs_val,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     next_pc;
  logic            accept, timeout, misalign;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign accept    = (state == VALID) && instr_ready;
  assign timeout   = (state == REQ) && !imem_ack && (to_cnt == TO_W'(ACK_TIMEOUT - 1));
  assign misalign  = (next_pc[1:0] != 2'b00);

  // Highest select bit wins; branch offset is in words.
  always_comb begin
    next_pc = pc_plus4;
    if (pc_next_c[2])      next_pc = rs_val;
    else if (pc_next_c[1]) next_pc = {pc_plus4[31:28], jaddr, 2'b00};
    else if (pc_next_c[0]) next_pc = pc_plus4 + {imm_ext[29:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE:  state_nxt = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack)     state_nxt = VALID;
        else if (timeout) state_nxt = ERR;
      end
      VALID: begin
        instr_valid = 1'b1;
        if (instr_ready) state_nxt = misalign ? ERR : REQ;
      end
      ERR:     err = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  // A misaligned accept still retires, but the PC stays on the faulting instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      instr    <= '0;
      retired  <= '0;
      err_code <= 2'b00;
      to_cnt   <= '0;
    end else begin
      if (state == REQ) begin
        if (imem_ack) begin
          instr  <= imem_rdata;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
          if (timeout) err_code <= 2'b01;
        end
      end
      if (accept) begin
        retired <= retired + 32'd1;
        if (misalign) err_code <= 2'b10;
        else          pc       <= next_pc;
      end
    end
  end

endmodule
